// File: rtl/receiver_native.sv
// UART receiver: synchronises din, validates the start bit, samples WORD_WIDTH
// data bits LSB-first at mid-bit and writes good words to a FIFO via we/full.
module receiver_native #(
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115200,
  parameter logic [31:0] WORD_WIDTH      = 32'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  full,
  output logic                  we,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int unsigned CPB  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned BW   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [BW-1:0] BIT_ZERO = BW'(0);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic                  sync_r;
  logic                  rx_r;
  state_t                state_r,  state_s;
  logic [CW-1:0]         cnt_r,    cnt_s;
  logic [BW-1:0]         idx_r,    idx_s;
  logic [WORD_WIDTH-1:0] shift_r,  shift_s;
  logic [WORD_WIDTH-1:0] dout_r,   dout_s;
  logic                  we_r,     we_s;
  logic                  fe_r,     fe_s;
  logic                  ov_r,     ov_s;

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= 1'b1;
      rx_r   <= 1'b1;
    end else begin
      sync_r <= din;
      rx_r   <= sync_r;
    end
  end

  // Next-state, counters, shift register and output pulses.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CNT_ONE;
    idx_s   = idx_r;
    shift_s = shift_r;
    dout_s  = dout_r;
    we_s    = 1'b0;
    fe_s    = 1'b0;
    ov_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (!rx_r) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_s = CNT_ZERO;
          idx_s = BIT_ZERO;
          if (!rx_r) begin
            state_s = ST_DATA;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == CNT_LAST) begin
          shift_s = {rx_r, shift_r[WORD_WIDTH-1:1]};
          cnt_s   = CNT_ZERO;
          idx_s   = idx_r + BIT_ONE;
          if (idx_r == BIT_LAST) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
          if (rx_r) begin
            // full is only consulted here, at the stop sample.
            if (!full) begin
              dout_s = shift_r;
              we_s   = 1'b1;
            end else begin
              ov_s   = 1'b1;
            end
            state_s = ST_IDLE;
          end else begin
            fe_s    = 1'b1;
            state_s = ST_BREAK;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        cnt_s = CNT_ZERO;
        if (rx_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= BIT_ZERO;
      shift_r <= {WORD_WIDTH{1'b0}};
      dout_r  <= {WORD_WIDTH{1'b0}};
      we_r    <= 1'b0;
      fe_r    <= 1'b0;
      ov_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      dout_r  <= dout_s;
      we_r    <= we_s;
      fe_r    <= fe_s;
      ov_r    <= ov_s;
    end
  end

  assign we          = we_r;
  assign dout        = dout_r;
  assign frame_error = fe_r;
  assign overrun     = ov_r;

endmodule

// File: tb/tb_receiver_native.sv
// Randomised bench for receiver_native: a frame-level model predicts every
// output pulse (kind, edge number, data) and a monitor matches DUT pulses.
module tb_receiver_native;

  localparam logic [31:0] CLK_HZ = 32'd23_040_000;
  localparam logic [31:0] BAUD   = 32'd115200;
  localparam int CPB  = int'(CLK_HZ / BAUD);
  localparam int HALF = CPB / 2;
  localparam int W    = 8;

  localparam int K_WE = 0;
  localparam int K_FE = 1;
  localparam int K_OV = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         din = 1'b1;
  logic         full = 1'b0;
  logic         we;
  logic         frame_error;
  logic         overrun;
  logic [W-1:0] dout;

  typedef struct {
    int           kind;
    int           cyc;
    logic [W-1:0] data;
  } exp_t;

  exp_t         q[$];
  exp_t         me;
  int           mkind;
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] last_word = 8'h00;
  logic [W-1:0] rd;
  logic [W-1:0] rv;
  bit           rok;
  bit           rf;

  receiver_native #(
    .CLOCK_FREQUENCY(CLK_HZ),
    .BAUD_RATE      (BAUD),
    .WORD_WIDTH     (32'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .full       (full),
    .we         (we),
    .dout       (dout),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, want, cyc);
    end
  endtask

  // Any output pulse must match the oldest predicted event exactly.
  always @(negedge clk) begin
    if (rst && (we || frame_error || overrun)) begin
      mkind = we ? K_WE : (frame_error ? K_FE : K_OV);
      check("exclusive", 32'(we) + 32'(frame_error) + 32'(overrun), 32'd1);
      if (q.size() == 0) begin
        check("spurious_event", {29'd0, we, frame_error, overrun}, 32'd0);
      end else begin
        me = q.pop_front();
        check("kind", 32'(mkind), 32'(me.kind));
        check("cycle", 32'(cyc), 32'(me.cyc));
        if (mkind == K_WE) begin
          check("dout", 32'(dout), 32'(me.data));
          last_word = me.data;
        end else begin
          check("dout_hold", 32'(dout), 32'(last_word));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; start edge is launched after edge n, so t0 = n + 3.
  task automatic send_frame(input logic [W-1:0] d, input bit stop_ok, input bit f,
                            input int stop_len);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    din = 1'b0;
    n = cyc;
    e.cyc  = n + 3 + HALF + (W + 1) * CPB;
    e.data = d;
    e.kind = !stop_ok ? K_FE : (f ? K_OV : K_WE);
    q.push_back(e);
    idle(CPB);
    full = f;
    for (int i = 0; i < W; i++) begin
      din = d[i];
      idle(CPB);
    end
    din = stop_ok;
    repeat (stop_len - 1) @(posedge clk);
  endtask

  task automatic glitch(input int g);
    @(posedge clk);
    #1;
    din = 1'b0;
    idle(g);
    din = 1'b1;
    idle(CPB);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 4 * CPB) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    idle(3);
    check("rst_we", 32'(we), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_fe", 32'(frame_error), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    rst = 1'b1;
    idle(CPB);

    send_frame(8'hA5, 1'b1, 1'b0, CPB);
    drain("single_a5");
    idle(CPB);
    check("hold_a5", 32'(dout), 32'h0000_00A5);

    send_frame(8'h00, 1'b1, 1'b0, CPB);
    send_frame(8'hFF, 1'b1, 1'b0, CPB);
    send_frame(8'h3C, 1'b1, 1'b0, CPB);
    drain("back_to_back");

    send_frame(8'h96, 1'b1, 1'b0, HALF + 1);
    send_frame(8'h69, 1'b1, 1'b0, CPB);
    drain("half_stop");

    glitch($urandom_range(1, HALF - 1));
    glitch(HALF);
    check("glitch_dout", 32'(dout), 32'h0000_0069);
    send_frame(8'h5A, 1'b1, 1'b0, CPB);
    drain("after_glitch");

    send_frame(8'h81, 1'b0, 1'b0, 1);
    idle(3000);
    din = 1'b1;
    idle(CPB);
    drain("framing");
    send_frame(8'h42, 1'b1, 1'b0, CPB);
    drain("after_break");

    send_frame(8'h77, 1'b1, 1'b1, CPB);
    drain("overrun");
    full = 1'b0;
    check("overrun_dout", 32'(dout), 32'h0000_0042);

    rv = 8'hC3;
    @(posedge clk);
    #1;
    din = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      din = rv[i];
      idle(CPB);
    end
    din = rv[3];
    idle(CPB / 2);
    rst = 1'b0;
    idle(4);
    check("midrst_we", 32'(we), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_fe", 32'(frame_error), 32'd0);
    check("midrst_ov", 32'(overrun), 32'd0);
    last_word = 8'h00;
    din = 1'b1;
    idle(4);
    rst = 1'b1;
    idle(CPB);
    send_frame(8'hC3, 1'b1, 1'b0, CPB);
    drain("after_reset");

    for (int k = 0; k < 12; k++) begin
      rd  = 8'($urandom);
      rok = ($urandom_range(0, 5) != 0);
      rf  = ($urandom_range(0, 3) == 0);
      if (rok) begin
        send_frame(rd, 1'b1, rf, $urandom_range(HALF + 1, 2 * CPB));
      end else begin
        send_frame(rd, 1'b0, rf, CPB);
        idle($urandom_range(0, 2 * CPB));
        din = 1'b1;
        idle(CPB);
      end
    end
    drain("random");
    full = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
